clock_bcd_serial_conv: RTL and testbench

- Parametrised, multi-channel binary-to-BCD converter for the digital-clock datapath; generation after the per-field combinational converter plus output pipeline stage.
- One shared sequential double-dabble (shift/add-3) engine processes channels in turn, trading latency for area.
- Adds a start/busy/valid handshake, optional 12-hour display mode on the hours channel, and per-channel overflow saturation.
- Sits between the time-keeping counters and the 7-segment/display mux.

---
 rtl/clock_bcd_serial_conv_if.sv | 26 ++
 rtl/clock_bcd_serial_conv.sv | 205 ++++++++++++++++++++
 tb/tb_clock_bcd_serial_conv.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_bcd_serial_conv_if.sv
// Handshake and data bundle between the time-keeping counters (master)
// and the serial binary-to-BCD converter (slave).
interface clock_bcd_serial_conv_if #(
  parameter int NUM_CH = 3,
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
);
  logic                         i_start;
  logic                         i_mode_12h;
  logic [NUM_CH*BIN_W-1:0]      i_bin;
  logic                         o_busy;
  logic                         o_valid;
  logic [NUM_CH*DIGITS*4-1:0]   o_bcd;
  logic                         o_pm;
  logic [NUM_CH-1:0]            o_overflow;

  modport master (
    output i_start, i_mode_12h, i_bin,
    input  o_busy, o_valid, o_bcd, o_pm, o_overflow
  );

  modport slave (
    input  i_start, i_mode_12h, i_bin,
    output o_busy, o_valid, o_bcd, o_pm, o_overflow
  );
endinterface

// File: rtl/clock_bcd_serial_conv.sv
// Multi-channel binary-to-BCD converter: one shared shift/add-3 engine walks the
// channels in turn, with optional 12-hour mapping and per-channel saturation.
module clock_bcd_serial_conv #(
  parameter int NUM_CH  = 3,
  parameter int BIN_W   = 6,
  parameter int DIGITS  = 2,
  parameter int HOUR_CH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  clock_bcd_serial_conv_if.slave  bus
);

  localparam int          IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int          BCD_W = DIGITS * 4;
  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_DONE
  } state_t;

  // 0 -> 12, 1..12 unchanged, 13 and above drop by 12 (covers out-of-range hours too)
  function automatic logic [BIN_W-1:0] map_12h(input logic [BIN_W-1:0] raw);
    logic [31:0] v;
    v = 32'(raw);
    if (v == 32'd0)       v = 32'd12;
    else if (v >= 32'd13) v = v - 32'd12;
    return v[BIN_W-1:0];
  endfunction

  // One double-dabble iteration: correct every digit >= 5, then shift in the next bit.
  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(
    input logic [BCD_W-1:0] scratch,
    input logic [BIN_W-1:0] shreg
  );
    logic [BCD_W-1:0]       s;
    logic [BCD_W+BIN_W-1:0] t;
    s = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[d*4 +: 4] >= 4'd5) s[d*4 +: 4] = s[d*4 +: 4] + 4'd3;
    end
    t = {s, shreg};
    return {t[BCD_W+BIN_W-2:0], 1'b0};
  endfunction

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         bin_q   [NUM_CH];
  logic [BIN_W-1:0]         bin_d   [NUM_CH];
  logic                     mode_q, mode_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]         val_q, val_d;
  logic [BIN_W-1:0]         shift_q, shift_d;
  logic [BCD_W-1:0]         scratch_q, scratch_d;
  logic [BCD_W-1:0]         bcd_sh_q [NUM_CH];
  logic [BCD_W-1:0]         bcd_sh_d [NUM_CH];
  logic                     pm_sh_q, pm_sh_d;
  logic [NUM_CH-1:0]        ovf_sh_q, ovf_sh_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [NUM_CH*BCD_W-1:0]  bcd_q, bcd_d;
  logic                     pm_q, pm_d;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;

  logic [BIN_W-1:0]         raw_ch;
  logic [BCD_W-1:0]         nines;
  logic                     is_hour;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    bin_d     = bin_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_sh_d  = bcd_sh_q;
    pm_sh_d   = pm_sh_q;
    ovf_sh_d  = ovf_sh_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    pm_d      = pm_q;
    ovf_d     = ovf_q;
    raw_ch    = bin_q[idx_q];
    is_hour   = (32'(idx_q) == 32'(HOUR_CH));
    nines     = '0;
    for (int d = 0; d < DIGITS; d++) nines[d*4 +: 4] = 4'd9;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          for (int c = 0; c < NUM_CH; c++) bin_d[c] = bus.i_bin[c*BIN_W +: BIN_W];
          mode_d  = bus.i_mode_12h;
          idx_d   = '0;
          pm_sh_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (mode_q && is_hour) begin
          val_d   = map_12h(raw_ch);
          shift_d = map_12h(raw_ch);
          pm_sh_d = (32'(raw_ch) >= 32'd12);
        end else begin
          val_d   = raw_ch;
          shift_d = raw_ch;
        end
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        {scratch_d, shift_d} = dabble_step(scratch_q, shift_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_STORE;
      end

      S_STORE: begin
        // Truncated digits would be wrong above the display range, so saturate instead.
        if (32'(val_q) >= LIMIT) begin
          bcd_sh_d[idx_q] = nines;
          ovf_sh_d[idx_q] = 1'b1;
        end else begin
          bcd_sh_d[idx_q] = scratch_q;
          ovf_sh_d[idx_q] = 1'b0;
        end
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        for (int c = 0; c < NUM_CH; c++) bcd_d[c*BCD_W +: BCD_W] = bcd_sh_q[c];
        pm_d    = pm_sh_q;
        ovf_d   = ovf_sh_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the small channel arrays are plain registers, so they reset like any other flop.
      state_q   <= S_IDLE;
      bin_q     <= '{default: '0};
      mode_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      val_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_sh_q  <= '{default: '0};
      pm_sh_q   <= 1'b0;
      ovf_sh_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      pm_q      <= 1'b0;
      ovf_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q   <= state_d;
      bin_q     <= bin_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_sh_q  <= bcd_sh_d;
      pm_sh_q   <= pm_sh_d;
      ovf_sh_q  <= ovf_sh_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      pm_q      <= pm_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_bcd      = bcd_q;
  assign bus.o_pm       = pm_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_clock_bcd_serial_conv.sv
// Directed bench for clock_bcd_serial_conv: default 6-bit instance plus a
// 7-bit instance for the saturation cases.
module tb_clock_bcd_serial_conv;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  clock_bcd_serial_conv_if #(.NUM_CH(3), .BIN_W(6), .DIGITS(2)) b0 ();
  clock_bcd_serial_conv_if #(.NUM_CH(3), .BIN_W(7), .DIGITS(2)) b7 ();

  clock_bcd_serial_conv #(.NUM_CH(3), .BIN_W(6), .DIGITS(2), .HOUR_CH(2)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (b0)
  );

  clock_bcd_serial_conv #(.NUM_CH(3), .BIN_W(7), .DIGITS(2), .HOUR_CH(2)) dut7 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (b7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulses i_start for one edge; returns 1 ns after the accepting edge.
  task automatic start_conv(input bit sel7, input logic [20:0] bin, input logic mode);
    @(posedge clk); #1;
    if (sel7) begin
      b7.i_bin = bin; b7.i_mode_12h = mode; b7.i_start = 1'b1;
    end else begin
      b0.i_bin = bin[17:0]; b0.i_mode_12h = mode; b0.i_start = 1'b1;
    end
    @(posedge clk); #1;
    b0.i_start = 1'b0;
    b7.i_start = 1'b0;
  endtask

  // Counts edges until o_valid; lat=200 signals timeout.
  task automatic wait_valid(input bit sel7, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (sel7 ? b7.o_valid : b0.o_valid) break;
      if (sel7 ? b7.o_busy : b0.o_busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (b0.o_busy !== 1'b0 || b0.o_valid !== 1'b0) begin errors++;
      $display("FAIL reset_busy_valid: got busy=%b valid=%b expected 0 0", b0.o_busy, b0.o_valid); end
    checks++; if (b0.o_bcd !== 24'h0 || b0.o_pm !== 1'b0 || b0.o_overflow !== 3'b000) begin errors++;
      $display("FAIL reset_outputs: got bcd=%h pm=%b ovf=%b expected 0", b0.o_bcd, b0.o_pm, b0.o_overflow); end
    checks++; if (b7.o_bcd !== 24'h0 || b7.o_overflow !== 3'b000) begin errors++;
      $display("FAIL reset_outputs7: got bcd=%h ovf=%b expected 0", b7.o_bcd, b7.o_overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_24h;
    int lat, bc;
    start_conv(1'b0, {3'b0, 6'd23, 6'd34, 6'd56}, 1'b0);
    checks++; if (b0.o_busy !== 1'b1) begin errors++;
      $display("FAIL 24h_busy_on_accept: got %b expected 1", b0.o_busy); end
    wait_valid(1'b0, lat, bc);
    checks++; if (lat !== 25) begin errors++;
      $display("FAIL 24h_latency: got %0d expected 25", lat); end
    checks++; if (bc !== 24) begin errors++;
      $display("FAIL 24h_busy_cycles: got %0d expected 24", bc); end
    checks++; if (b0.o_bcd !== 24'h233456) begin errors++;
      $display("FAIL 24h_bcd: got %h expected 233456", b0.o_bcd); end
    checks++; if (b0.o_pm !== 1'b0 || b0.o_overflow !== 3'b000 || b0.o_busy !== 1'b0) begin errors++;
      $display("FAIL 24h_flags: got pm=%b ovf=%b busy=%b expected 0 000 0", b0.o_pm, b0.o_overflow, b0.o_busy); end
    @(posedge clk); #1;
    checks++; if (b0.o_valid !== 1'b0 || b0.o_bcd !== 24'h233456) begin errors++;
      $display("FAIL 24h_pulse_hold: got valid=%b bcd=%h expected 0 233456", b0.o_valid, b0.o_bcd); end
  endtask

  task automatic test_12h;
    logic [5:0]  hrs  [4] = '{6'd0, 6'd12, 6'd13, 6'd23};
    logic [23:0] exp_b[4] = '{24'h124507, 24'h124507, 24'h014507, 24'h114507};
    logic        exp_p[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      start_conv(1'b0, {3'b0, hrs[i], 6'd45, 6'd7}, 1'b1);
      wait_valid(1'b0, lat, bc);
      checks++; if (b0.o_bcd !== exp_b[i] || b0.o_pm !== exp_p[i]) begin errors++;
        $display("FAIL 12h_hour%0d: got bcd=%h pm=%b expected %h %b", hrs[i], b0.o_bcd, b0.o_pm, exp_b[i], exp_p[i]); end
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    start_conv(1'b1, {7'd100, 7'd99, 7'd127}, 1'b0);
    wait_valid(1'b1, lat, bc);
    checks++; if (lat !== 28) begin errors++;
      $display("FAIL ovf_latency: got %0d expected 28", lat); end
    checks++; if (b7.o_bcd !== 24'h999999 || b7.o_overflow !== 3'b101) begin errors++;
      $display("FAIL ovf_saturate: got bcd=%h ovf=%b expected 999999 101", b7.o_bcd, b7.o_overflow); end
    start_conv(1'b1, {7'd5, 7'd10, 7'd99}, 1'b0);
    wait_valid(1'b1, lat, bc);
    checks++; if (b7.o_bcd !== 24'h051099 || b7.o_overflow !== 3'b000) begin errors++;
      $display("FAIL ovf_clear: got bcd=%h ovf=%b expected 051099 000", b7.o_bcd, b7.o_overflow); end
  endtask

  task automatic test_start_ignored;
    int nvalid = 0;
    int first_at = -1;
    logic [23:0] first_bcd = '0;
    int lat, bc;
    start_conv(1'b0, {3'b0, 6'd1, 6'd2, 6'd3}, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      if (k == 4 || k == 24) begin
        b0.i_start = 1'b1; b0.i_bin = {6'd11, 6'd22, 6'd33}; b0.i_mode_12h = 1'b1;
      end else begin
        b0.i_start = 1'b0;
      end
      @(posedge clk); #1;
      if (b0.o_valid) begin
        nvalid++;
        if (first_at < 0) begin first_at = k; first_bcd = b0.o_bcd; end
      end
    end
    b0.i_start = 1'b0;
    checks++; if (nvalid !== 1 || first_at !== 25) begin errors++;
      $display("FAIL ignore_count: got %0d pulses first at %0d expected 1 at 25", nvalid, first_at); end
    checks++; if (first_bcd !== 24'h010203) begin errors++;
      $display("FAIL ignore_data: got %h expected 010203", first_bcd); end
    start_conv(1'b0, {3'b0, 6'd11, 6'd22, 6'd33}, 1'b0);
    wait_valid(1'b0, lat, bc);
    checks++; if (lat !== 25 || b0.o_bcd !== 24'h112233) begin errors++;
      $display("FAIL ignore_next: got lat=%0d bcd=%h expected 25 112233", lat, b0.o_bcd); end
  endtask

  task automatic test_reset_mid;
    int nvalid = 0;
    int lat, bc;
    start_conv(1'b0, {3'b0, 6'd23, 6'd59, 6'd59}, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (b0.o_busy !== 1'b0 || b0.o_bcd !== 24'h0 || b0.o_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_async: got busy=%b bcd=%h valid=%b expected 0 0 0", b0.o_busy, b0.o_bcd, b0.o_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    b0.i_bin = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (b0.o_valid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++;
      $display("FAIL midreset_no_valid: got %0d pulses expected 0", nvalid); end
    start_conv(1'b0, 21'h0, 1'b0);
    wait_valid(1'b0, lat, bc);
    checks++; if (lat !== 25 || b0.o_bcd !== 24'h0) begin errors++;
      $display("FAIL midreset_restart: got lat=%0d bcd=%h expected 25 000000", lat, b0.o_bcd); end
  endtask

  task automatic test_back_to_back;
    int vat[$];
    logic [23:0] vbcd[$];
    int unstable = 0;
    logic [23:0] held = '0;
    @(posedge clk); #1;
    b0.i_bin = {6'd12, 6'd34, 6'd56}; b0.i_mode_12h = 1'b0; b0.i_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 10) b0.i_bin = {6'd1, 6'd2, 6'd3};
      @(posedge clk); #1;
      if (b0.o_valid) begin
        vat.push_back(k); vbcd.push_back(b0.o_bcd); held = b0.o_bcd;
      end else if (vat.size() > 0 && b0.o_bcd !== held) begin
        unstable++;
      end
    end
    b0.i_start = 1'b0;
    checks++; if (vat.size() !== 3) begin errors++;
      $display("FAIL b2b_count: got %0d pulses expected 3", vat.size()); end
    else begin
      checks++; if (vat[0] !== 25 || vat[1] !== 51 || vat[2] !== 77) begin errors++;
        $display("FAIL b2b_spacing: got %0d %0d %0d expected 25 51 77", vat[0], vat[1], vat[2]); end
      checks++; if (vbcd[0] !== 24'h123456 || vbcd[1] !== 24'h010203) begin errors++;
        $display("FAIL b2b_data: got %h %h expected 123456 010203", vbcd[0], vbcd[1]); end
    end
    checks++; if (unstable !== 0) begin errors++;
      $display("FAIL b2b_hold: got %0d changes between pulses expected 0", unstable); end
  endtask

  initial begin
    rst_n = 1'b0;
    b0.i_start = 1'b0; b0.i_mode_12h = 1'b0; b0.i_bin = '0;
    b7.i_start = 1'b0; b7.i_mode_12h = 1'b0; b7.i_bin = '0;
    test_reset;
    test_24h;
    test_12h;
    test_overflow;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
